amp_seq_ctrl: RTL and testbench

AMP_SEQ_CTRL -- requirements
Module: amp_seq_ctrl

---
 rtl/toi2s_pkg.sv | 35 +++
 rtl/amp_seq_ctrl.sv | 118 +++++++++++
 tb/tb_amp_seq_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/toi2s_pkg.sv
// toi2s_pkg: amplifier init table, device address and sequencer state encoding
package toi2s_pkg;

    localparam logic [6:0] AMP_DEV_ADDR = 7'h2C;
    localparam int AMP_INIT_LEN = 8;

    typedef struct packed {
        logic [7:0] reg_addr;
        logic [7:0] data;
    } amp_init_entry_t;

    // Page/book select, hold in Hi-Z while configuring, then release to play last
    localparam amp_init_entry_t AMP_INIT_TBL [AMP_INIT_LEN] = '{
        '{8'h00, 8'h00},
        '{8'h7F, 8'h00},
        '{8'h03, 8'h02},
        '{8'h02, 8'h00},
        '{8'h4C, 8'h30},
        '{8'h54, 8'h03},
        '{8'h68, 8'h02},
        '{8'h03, 8'h03}
    };

    typedef enum logic [2:0] {
        S_IDLE,
        S_PWRUP,
        S_WRITE,
        S_GAP,
        S_WAIT_LOCK,
        S_PLAY,
        S_MUTE_DN,
        S_FAULT
    } amp_seq_state_t;

endpackage

// File: rtl/amp_seq_ctrl.sv
// amp_seq_ctrl: amplifier power-up, I2C init table download and mute sequencing
module amp_seq_ctrl
    import toi2s_pkg::*;
#(
    parameter int PWRUP_CYC = 4800,
    parameter int GAP_CYC   = 48,
    parameter int MUTE_CYC  = 480,
    parameter int TMO_CYC   = 4096,
    parameter int MAX_RETRY = 3
) (
    input  logic       clk,
    input  logic       resetb,
    input  logic       ena,
    input  logic       cfg_run,
    input  logic       rx_lock,
    output logic       i2c_req,
    output logic [6:0] i2c_dev,
    output logic [7:0] i2c_reg,
    output logic [7:0] i2c_wdata,
    input  logic       i2c_ack,
    input  logic       i2c_nack,
    output logic       amp_nenable,
    output logic       amp_nmute,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic [2:0] state_mon
);

    localparam int TMAX = (PWRUP_CYC > TMO_CYC ? PWRUP_CYC : TMO_CYC) > MUTE_CYC
                        ? (PWRUP_CYC > TMO_CYC ? PWRUP_CYC : TMO_CYC) : MUTE_CYC;
    localparam int TW = $clog2((TMAX > GAP_CYC ? TMAX : GAP_CYC) + 1);
    localparam int IW = $clog2(AMP_INIT_LEN);
    localparam int RW = $clog2(MAX_RETRY + 1);
    localparam logic [IW-1:0] LAST = IW'(AMP_INIT_LEN - 1);

    amp_seq_state_t state, state_d;
    logic [TW-1:0] timer, timer_d;
    logic [IW-1:0] idx, idx_d;
    logic [RW-1:0] retry, retry_d;
    logic done_d, run_en, tick, ack, nack, can_retry;

    assign run_en    = ena & cfg_run;
    assign tick      = timer == '0;
    assign ack       = i2c_ack & ~i2c_nack;
    assign nack      = i2c_nack | (tick & ~i2c_ack);
    assign can_retry = retry < RW'(MAX_RETRY);

    always_ff @(posedge clk or negedge resetb)
        if (!resetb) begin
            state <= S_IDLE;
            timer <= '0;
            idx   <= '0;
            retry <= '0;
            done  <= 1'b0;
        end else begin
            state <= state_d;
            timer <= timer_d;
            idx   <= idx_d;
            retry <= retry_d;
            done  <= done_d;
        end

    always_comb begin
        state_d = state;
        timer_d = tick ? timer : timer - TW'(1);
        idx_d   = idx;
        retry_d = retry;
        done_d  = done;
        case (state)
            S_IDLE: if (run_en) begin
                state_d = S_PWRUP;
                timer_d = TW'(PWRUP_CYC - 1);
                idx_d   = '0;
                retry_d = '0;
            end
            S_PWRUP, S_GAP: if (tick) begin
                state_d = S_WRITE;
                timer_d = TW'(TMO_CYC - 1);
            end
            S_WRITE: if (ack) begin
                idx_d   = (idx == LAST) ? idx : idx + IW'(1);
                retry_d = '0;
                done_d  = idx == LAST;
                state_d = (idx == LAST) ? S_WAIT_LOCK : S_GAP;
                timer_d = TW'(GAP_CYC - 1);
            end else if (nack) begin
                retry_d = can_retry ? retry + RW'(1) : retry;
                state_d = can_retry ? S_GAP : S_FAULT;
                timer_d = TW'(GAP_CYC - 1);
            end
            S_WAIT_LOCK: state_d = rx_lock ? S_PLAY : S_WAIT_LOCK;
            S_PLAY: state_d = rx_lock ? S_PLAY : S_WAIT_LOCK;
            S_MUTE_DN: if (tick) begin
                state_d = S_IDLE;
                done_d  = 1'b0;
            end
            S_FAULT: state_d = run_en ? S_FAULT : S_IDLE;
        endcase
        // A pending transfer is always allowed to finish before muting down
        if (!run_en && (state inside {S_PWRUP, S_GAP, S_WAIT_LOCK, S_PLAY}
                        || (state == S_WRITE && (ack || nack)))) begin
            state_d = S_MUTE_DN;
            timer_d = TW'(MUTE_CYC - 1);
        end
    end

    assign i2c_req     = state == S_WRITE;
    assign i2c_dev     = AMP_DEV_ADDR;
    assign i2c_reg     = AMP_INIT_TBL[idx].reg_addr;
    assign i2c_wdata   = AMP_INIT_TBL[idx].data;
    assign amp_nenable = state inside {S_IDLE, S_FAULT};
    assign amp_nmute   = state == S_PLAY && rx_lock;
    assign busy        = state inside {S_PWRUP, S_WRITE, S_GAP};
    assign fault       = state == S_FAULT;
    assign state_mon   = state;

endmodule

// File: tb/tb_amp_seq_ctrl.sv
// tb_amp_seq_ctrl: directed vectors plus randomized I2C responder against a transaction-level model
module tb_amp_seq_ctrl;

    localparam int PW = 40, GP = 5, MU = 12, TM = 20, MR = 3, LEN = 8;
    localparam logic [6:0] DEV = 7'h2C;
    localparam int K_ACK = 0, K_NACK = 1, K_BOTH = 2, K_TMO = 3;

    logic clk = 1'b0;
    logic resetb, ena, cfg_run, rx_lock, i2c_ack, i2c_nack;
    logic i2c_req, amp_nenable, amp_nmute, busy, done, fault;
    logic [6:0] i2c_dev;
    logic [7:0] i2c_reg, i2c_wdata;
    logic [2:0] state_mon;

    typedef struct packed {
        logic ena, cfg, rx, nmute;
        logic [2:0] st;
    } vec_t;

    logic [15:0] tbl [LEN] = '{16'h0000, 16'h7F00, 16'h0302, 16'h0200,
                               16'h4C30, 16'h5403, 16'h6802, 16'h0303};
    vec_t vec [7];
    int checks = 0, failures = 0;
    int q_kind[$], q_dly[$];
    int sends [LEN];
    bit rnd_mode = 1'b0;
    int att, oc;
    bit ok;

    amp_seq_ctrl #(.PWRUP_CYC(PW), .GAP_CYC(GP), .MUTE_CYC(MU), .TMO_CYC(TM), .MAX_RETRY(MR)) dut (
        .clk(clk), .resetb(resetb), .ena(ena), .cfg_run(cfg_run), .rx_lock(rx_lock),
        .i2c_req(i2c_req), .i2c_dev(i2c_dev), .i2c_reg(i2c_reg), .i2c_wdata(i2c_wdata),
        .i2c_ack(i2c_ack), .i2c_nack(i2c_nack), .amp_nenable(amp_nenable), .amp_nmute(amp_nmute),
        .busy(busy), .done(done), .fault(fault), .state_mon(state_mon)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push(input int k, input int d);
        q_kind.push_back(k);
        q_dly.push_back(d);
    endtask

    task automatic pick(output int kind, output int dly);
        if (q_kind.size() != 0) begin
            kind = q_kind.pop_front();
            dly  = q_dly.pop_front();
        end else if (rnd_mode) begin
            int r = $urandom_range(99);
            kind = r < 70 ? K_ACK : r < 85 ? K_NACK : r < 92 ? K_BOTH : K_TMO;
            dly  = $urandom_range(TM - 1);
        end else begin
            kind = K_ACK;
            dly  = 0;
        end
    endtask

    // Called at a negedge where req is already low; counts idle negedges up to the request
    task automatic wait_req(input int exp_n, output bit got);
        int n = 0;
        while (!i2c_req && n <= exp_n + 4) begin
            n++;
            @(negedge clk);
        end
        chk("req_spacing", n, exp_n);
        got = i2c_req;
    endtask

    task automatic start_run();
        ena = 1'b1;
        cfg_run = 1'b1;
        @(negedge clk);
        chk("pwrup_nenable", amp_nenable, 0);
        chk("pwrup_state", state_mon, 1);
        chk("pwrup_busy", busy, 1);
        chk("pwrup_req", i2c_req, 0);
    endtask

    task automatic to_idle();
        int n = 0;
        cfg_run = 1'b0;
        rx_lock = 1'b0;
        while (state_mon != 3'd0 && n <= MU + 4) begin
            n++;
            @(negedge clk);
        end
        chk("idle_state", state_mon, 0);
        chk("idle_nenable", amp_nenable, 1);
        chk("idle_fault", fault, 0);
        chk("idle_done", done, 0);
    endtask

    // Acts as the I2C master stub for a whole run; outcome 1 = done, 2 = fault, 3 = lost
    task automatic serve(output int attempts, output int outcome);
        int e_idx = 0, e_ret = 0, kind, dly, j;
        bit got, stable, responded;
        attempts = 0;
        outcome = 0;
        foreach (sends[i]) sends[i] = 0;
        wait_req(PW, got);
        while (got && outcome == 0 && attempts < LEN * (MR + 1)) begin
            attempts++;
            sends[e_idx]++;
            chk("req_reg", i2c_reg, tbl[e_idx][15:8]);
            chk("req_data", i2c_wdata, tbl[e_idx][7:0]);
            chk("req_dev", i2c_dev, DEV);
            pick(kind, dly);
            j = 0;
            stable = 1'b1;
            responded = 1'b0;
            while (1) begin
                if (kind != K_TMO && j == dly) begin
                    i2c_ack  = kind != K_NACK;
                    i2c_nack = kind != K_ACK;
                    responded = 1'b1;
                    @(negedge clk);
                    i2c_ack  = 1'b0;
                    i2c_nack = 1'b0;
                    break;
                end
                @(negedge clk);
                if (!i2c_req || j > TM) break;
                j++;
                if ({i2c_reg, i2c_wdata} !== tbl[e_idx]) stable = 1'b0;
            end
            if (kind == K_TMO) chk("tmo_len", j + 1, TM);
            else chk("resp_taken", responded, 1);
            chk("req_stable", stable, 1);
            chk("req_drop", i2c_req, 0);
            if (kind == K_ACK) begin
                if (e_idx == LEN - 1) outcome = 1;
                else begin
                    e_idx++;
                    e_ret = 0;
                end
            end else if (e_ret < MR) e_ret++;
            else outcome = 2;
            if (outcome == 0) begin
                chk("gap_state", state_mon, 3);
                wait_req(GP, got);
            end
        end
        if (outcome == 1) begin
            chk("end_done", done, 1);
            chk("end_state", state_mon, 4);
            chk("end_busy", busy, 0);
            chk("end_nenable", amp_nenable, 0);
            chk("end_nmute", amp_nmute, 0);
        end else if (outcome == 2) begin
            chk("fault_flag", fault, 1);
            chk("fault_state", state_mon, 7);
            chk("fault_nenable", amp_nenable, 1);
            chk("fault_nmute", amp_nmute, 0);
            chk("fault_done", done, 0);
        end else outcome = 3;
    endtask

    initial begin
        vec[0] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4};
        vec[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd5};
        vec[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd5};
        vec[3] = '{1'b1, 1'b1, 1'b0, 1'b0, 3'd4};
        vec[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 3'd5};
        vec[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 3'd5};
        vec[6] = '{1'b0, 1'b1, 1'b1, 1'b1, 3'd6};
        resetb = 1'b0;
        ena = 1'b0;
        cfg_run = 1'b0;
        rx_lock = 1'b0;
        i2c_ack = 1'b0;
        i2c_nack = 1'b0;
        #1;
        chk("rst_state", state_mon, 0);
        chk("rst_nenable", amp_nenable, 1);
        chk("rst_nmute", amp_nmute, 0);
        chk("rst_req", i2c_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_fault", fault, 0);
        chk("rst_reg", i2c_reg, tbl[0][15:8]);
        @(negedge clk);
        resetb = 1'b1;

        // Clean run, then lock/unlock vectors in WAIT_LOCK/PLAY and mute-down
        @(negedge clk);
        start_run();
        serve(att, oc);
        chk("s1_attempts", att, 8);
        chk("s1_outcome", oc, 1);
        for (int i = 0; i < 7; i++) begin
            ena = vec[i].ena;
            cfg_run = vec[i].cfg;
            rx_lock = vec[i].rx;
            #1;
            chk("vec_nmute", amp_nmute, vec[i].nmute);
            @(negedge clk);
            chk("vec_state", state_mon, vec[i].st);
            chk("vec_req", i2c_req, 0);
            chk("vec_nenable", amp_nenable, 0);
            chk("vec_done", done, 1);
        end
        rx_lock = 1'b0;
        begin
            int n = 0;
            while (state_mon == 3'd6 && n <= MU + 4) begin
                n++;
                @(negedge clk);
            end
            chk("mute_len", n, MU);
            chk("mute_end_nenable", amp_nenable, 1);
            chk("mute_end_state", state_mon, 0);
            chk("mute_end_done", done, 0);
        end

        // Entry 3 NACKed twice then accepted
        push(K_ACK, 0); push(K_ACK, 1); push(K_ACK, 2);
        push(K_NACK, 2); push(K_BOTH, 0); push(K_ACK, 3);
        start_run();
        serve(att, oc);
        chk("s2_attempts", att, 10);
        chk("s2_outcome", oc, 1);
        chk("s2_sends3", sends[3], 3);
        chk("s2_fault", fault, 0);
        to_idle();

        // Entry 0 never answered: four timeouts then FAULT until run_en drops
        repeat (4) push(K_TMO, 0);
        start_run();
        serve(att, oc);
        chk("s3_attempts", att, 4);
        chk("s3_outcome", oc, 2);
        repeat (5) @(negedge clk);
        chk("s3_hold_state", state_mon, 7);
        chk("s3_hold_fault", fault, 1);
        cfg_run = 1'b0;
        @(negedge clk);
        chk("s3_idle", state_mon, 0);
        chk("s3_fault_clr", fault, 0);
        chk("s3_nenable", amp_nenable, 1);

        // cfg_run drops with a request outstanding; run_en re-raised during mute is deferred
        start_run();
        wait_req(PW, ok);
        cfg_run = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("s5_req_held", i2c_req, 1);
            chk("s5_reg_held", i2c_reg, tbl[0][15:8]);
        end
        i2c_ack = 1'b1;
        @(negedge clk);
        i2c_ack = 1'b0;
        chk("s5_mute_state", state_mon, 6);
        chk("s5_req_drop", i2c_req, 0);
        chk("s5_nmute", amp_nmute, 0);
        chk("s5_nenable", amp_nenable, 0);
        begin
            int n = 0;
            while (state_mon == 3'd6 && n <= MU + 4) begin
                n++;
                if (n == 3) cfg_run = 1'b1;
                @(negedge clk);
            end
            chk("s5_mute_len", n, MU);
        end
        chk("s5_idle", state_mon, 0);
        chk("s5_idle_nenable", amp_nenable, 1);
        @(negedge clk);
        chk("s5_restart", state_mon, 1);
        to_idle();

        // Reset pulse in GAP, then a full run from entry 0
        start_run();
        wait_req(PW, ok);
        i2c_ack = 1'b1;
        @(negedge clk);
        i2c_ack = 1'b0;
        @(negedge clk);
        chk("s6_in_gap", state_mon, 3);
        resetb = 1'b0;
        #1;
        chk("s6_rst_state", state_mon, 0);
        chk("s6_rst_req", i2c_req, 0);
        chk("s6_rst_nenable", amp_nenable, 1);
        chk("s6_rst_nmute", amp_nmute, 0);
        chk("s6_rst_busy", busy, 0);
        chk("s6_rst_done", done, 0);
        chk("s6_rst_fault", fault, 0);
        chk("s6_rst_reg", i2c_reg, tbl[0][15:8]);
        @(negedge clk);
        resetb = 1'b1;
        @(negedge clk);
        chk("s6_pwrup", state_mon, 1);
        serve(att, oc);
        chk("s6_attempts", att, 8);
        chk("s6_outcome", oc, 1);
        chk("s6_sends0", sends[0], 1);
        to_idle();

        // Randomized responder
        rnd_mode = 1'b1;
        for (int r = 0; r < 12; r++) begin
            start_run();
            serve(att, oc);
            chk("rnd_not_lost", oc != 3, 1);
            if (oc == 1) begin
                rx_lock = 1'b1;
                @(negedge clk);
                chk("rnd_play", state_mon, 5);
                chk("rnd_nmute", amp_nmute, 1);
            end
            to_idle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
